// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Sequencer for the 8x8 array multiplier datapath. It collects operand A and
//   then operand B as bytes on a valid/ready input stream and launches the
//   multiplier with a one-cycle pulse. It then waits the core's fixed latency,
//   captures the 16-bit product, and returns it LSB first as two bytes on a
//   valid/ready output stream. Only one operation is in flight at a time.
//
//   Optional feature macro: MULT_ACCUM_EN
//     defined   : prod is a 16-bit accumulator (prod <= prod + mul_p). acc_clr
//                 clears it in LOAD_A, and an A byte offered on the same edge
//                 is still accepted.
//     undefined : plain multiply (prod <= mul_p); acc_clr has no effect.
//
// Parameters
//   MUL_LAT  cycles from mul_start high to mul_p valid (0..15, 0 = combinational)
//   CNT_W    width of op_count
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous reset, active-high
//   in_data    in   operand byte
//   in_valid   in   in_data valid
//   in_ready   out  block accepts in_data this cycle
//   mul_a      out  multiplier operand A
//   mul_b      out  multiplier operand B
//   mul_start  out  one-cycle launch pulse to multiplier
//   mul_p      in   multiplier product
//   out_data   out  product byte
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   busy       out  high in every state except LOAD_A
//   acc_clr    in   accumulator clear (MULT_ACCUM_EN only)
//   op_count   out  completed operations, wraps at 2^CNT_W
//
// state   | meaning
// --------+---------------------------------------------------------
// LOAD_A  | idle, waiting for operand A byte
// LOAD_B  | waiting for operand B byte, launches multiplier on accept
// WAIT    | counting down multiplier latency, captures product at 0
// OUT_LO  | presenting product[7:0]
// OUT_HI  | presenting product[15:8], counts the operation on accept

module mult_seq_ctrl #(
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  output logic             mul_start,
  input  logic [15:0]      mul_p,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  input  logic             acc_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_OUT_LO = 3'd3;
  localparam logic [2:0] S_OUT_HI = 3'd4;

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [15:0] prod;
  logic [15:0] prod_cap;
  logic        clr_now;

`ifdef MULT_ACCUM_EN
  assign prod_cap = prod + mul_p;
  assign clr_now  = acc_clr;
`else
  // In plain multiply mode the low product byte leaves through out_data at
  // capture time, so prod[7:0] and acc_clr have no reader.
  logic [8:0] unused_plain;
  assign unused_plain = {acc_clr, prod[7:0]};
  assign prod_cap     = mul_p;
  assign clr_now      = 1'b0;
`endif

  // Outputs are registered and updated together with the state transition,
  // so each output always reflects the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD_A;
      cnt       <= 4'd0;
      prod      <= 16'd0;
      mul_a     <= 8'd0;
      mul_b     <= 8'd0;
      mul_start <= 1'b0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        S_LOAD_A: begin
          if (clr_now)
            prod <= 16'd0;
          if (in_valid) begin
            mul_a <= in_data;
            busy  <= 1'b1;
            state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            mul_b     <= in_data;
            mul_start <= 1'b1;
            cnt       <= LAT;
            in_ready  <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            prod      <= prod_cap;
            out_data  <= prod_cap[7:0];
            out_valid <= 1'b1;
            state     <= S_OUT_LO;
          end
        end
        S_OUT_LO: begin
          if (out_ready) begin
            out_data <= prod[15:8];
            state    <= S_OUT_HI;
          end
        end
        S_OUT_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state     <= S_LOAD_A;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 3;
  localparam int BOUND   = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       in_data = 8'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       mul_a, mul_b;
  logic             mul_start;
  logic [15:0]      mul_p;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             acc_clr = 1'b0;
  logic [CNT_W-1:0] op_count;

  int n_chk = 0;
  int n_pass = 0;
  int ms_cycles = 0;
  int both_cnt = 0;
  int exp_count = 0;
  logic [15:0] model_acc = 16'd0;

  mult_seq_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_p(mul_p), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .acc_clr(acc_clr), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Multiplier core stand-in: the product is valid only in the single cycle
  // that lies exactly MUL_LAT cycles after the launch pulse; otherwise the
  // bus carries junk, so a capture on the wrong edge is visible.
  logic [15:0] pipe_p [MUL_LAT];
  logic        pipe_v [MUL_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_p[i] <= 16'd0;
      end
    end else begin
      pipe_v[0] <= mul_start;
      pipe_p[0] <= {8'h00, mul_a} * {8'h00, mul_b};
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end
  assign mul_p = pipe_v[MUL_LAT-1] ? pipe_p[MUL_LAT-1] : 16'hBAD1;

  always @(negedge clk) begin
    if (!rst) begin
      if (mul_start) ms_cycles++;
      if (in_ready && out_valid) both_cnt++;
    end
  end

  // Reference model: the product (or running sum) of the operand pairs.
  task automatic model_op(input logic [7:0] a, input logic [7:0] b,
                          input logic clr, output logic [15:0] p);
`ifdef MULT_ACCUM_EN
    if (clr) model_acc = 16'd0;
    model_acc = model_acc + ({8'h00, a} * {8'h00, b});
    p = model_acc;
`else
    p = {8'h00, a} * {8'h00, b};
`endif
    exp_count++;
  endtask

  task automatic timeout(input string what);
    n_chk++;
    $display("FAIL timeout_%s: no handshake within %0d cycles", what, BOUND);
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < BOUND) begin @(negedge clk); t++; end
    if (t >= BOUND) timeout("in");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
`ifdef MULT_ACCUM_EN
    model_acc = 16'd0;
`endif
  endtask

  // lat counts the cycle in which B is accepted as cycle 0.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic clr_a, output int lat);
    out_ready = 1'b0;
    acc_clr = clr_a;
    send_byte(a);
    acc_clr = 1'b0;
    send_byte(b);
    lat = 1;
    while (!out_valid && lat < BOUND) begin @(negedge clk); lat++; end
    if (!out_valid) timeout("out");
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < BOUND) begin @(negedge clk); t++; end
    if (!out_valid) timeout("byte");
  endtask

  task automatic take(output logic [7:0] lo, output logic [7:0] hi);
    out_ready = 1'b1;
    wait_valid();
    lo = out_data;
    @(negedge clk);
    wait_valid();
    hi = out_data;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({in_ready, out_valid, busy, mul_start} !== 4'b1000)
      $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, busy, mul_start});
    else n_pass++;
    n_chk++;
    if ({mul_a, mul_b} !== 16'h0000)
      $display("FAIL reset_operands: got %h want 0000", {mul_a, mul_b});
    else n_pass++;
    n_chk++;
    if (op_count !== '0) $display("FAIL reset_count: got %0d want 0", op_count);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [15:0] p;
    logic [7:0] lo, hi;
    int lat, ms0;
    clear_acc();
    ms0 = ms_cycles;
    model_op(8'h0F, 8'h0F, 1'b0, p);
    issue(8'h0F, 8'h0F, 1'b0, lat);
    n_chk++;
    if (ms_cycles - ms0 !== 1) $display("FAIL basic_start_width: got %0d want 1", ms_cycles - ms0);
    else n_pass++;
    n_chk++;
    if ({mul_a, mul_b, busy} !== {8'h0F, 8'h0F, 1'b1})
      $display("FAIL basic_operands: got %h/%h busy %b want 0f/0f busy 1", mul_a, mul_b, busy);
    else n_pass++;
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p || p !== 16'h00E1) $display("FAIL basic_bytes: got %h%h want %h (00e1)", hi, lo, p);
    else n_pass++;
    n_chk++;
    if (op_count !== CNT_W'(exp_count) || busy !== 1'b0)
      $display("FAIL basic_count: got %0d busy %b want %0d busy 0", op_count, busy, exp_count);
    else n_pass++;
  endtask

  task automatic test_corners();
    logic [15:0] p;
    logic [7:0] lo, hi;
    int lat;
    clear_acc();
    model_op(8'hFF, 8'hFF, 1'b0, p);
    issue(8'hFF, 8'hFF, 1'b0, lat);
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p || p !== 16'hFE01) $display("FAIL corner_ffff: got %h%h want %h (fe01)", hi, lo, p);
    else n_pass++;
    clear_acc();
    model_op(8'h00, 8'hAB, 1'b0, p);
    issue(8'h00, 8'hAB, 1'b0, lat);
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p || p !== 16'h0000) $display("FAIL corner_zero: got %h%h want %h (0000)", hi, lo, p);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [15:0] p;
    logic [7:0] lo, hi;
    int lat;
    clear_acc();
    model_op(8'h12, 8'h34, 1'b0, p);
    issue(8'h12, 8'h34, 1'b0, lat);
    n_chk++;
    if (lat !== MUL_LAT + 2) $display("FAIL latency: got %0d want %0d", lat, MUL_LAT + 2);
    else n_pass++;
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p || p !== 16'h03A8) $display("FAIL latency_bytes: got %h%h want %h (03a8)", hi, lo, p);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] p;
    logic [7:0] lo, hi;
    int lat;
    clear_acc();
    model_op(8'h0F, 8'h0F, 1'b0, p);
    issue(8'h0F, 8'h0F, 1'b0, lat);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (out_data !== p[7:0]) $display("FAIL bp_hold_data: cycle %0d got %h want %h", i, out_data, p[7:0]);
      else n_pass++;
      n_chk++;
      if ({out_valid, in_ready} !== 2'b10)
        $display("FAIL bp_handshake: cycle %0d got valid %b ready %b want 1 0", i, out_valid, in_ready);
      else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p) $display("FAIL bp_bytes: got %h%h want %h", hi, lo, p);
    else n_pass++;
    n_chk++;
    if ({mul_a, mul_b} !== 16'h0F0F) $display("FAIL bp_ignored_in: got %h want 0f0f", {mul_a, mul_b});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    logic [7:0] lo, hi;
    int lat;
    out_ready = 1'b1;
    send_byte(8'h21);
    send_byte(8'h43);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({in_ready, out_valid, busy, mul_start, mul_a, mul_b, op_count} !== {4'b1000, 16'h0000, CNT_W'(0)})
      $display("FAIL midreset_outputs: got rdy %b vld %b busy %b start %b a %h b %h cnt %0d",
               in_ready, out_valid, busy, mul_start, mul_a, mul_b, op_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    model_acc = 16'd0;
    repeat (MUL_LAT + 3) @(negedge clk);
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL midreset_abandon: got valid %b ready %b want 0 1", out_valid, in_ready);
    else n_pass++;
    model_op(8'h02, 8'h03, 1'b0, p);
    issue(8'h02, 8'h03, 1'b0, lat);
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p || p !== 16'h0006) $display("FAIL midreset_next: got %h%h want %h (0006)", hi, lo, p);
    else n_pass++;
    n_chk++;
    if (op_count !== CNT_W'(1)) $display("FAIL midreset_count: got %0d want 1", op_count);
    else n_pass++;
  endtask

  task automatic test_accum();
    logic [15:0] p;
    logic [7:0] lo, hi;
    int lat;
    clear_acc();
    model_op(8'h10, 8'h10, 1'b0, p);
    issue(8'h10, 8'h10, 1'b0, lat);
    take(lo, hi);
    model_op(8'h10, 8'h10, 1'b0, p);
    acc_clr = 1'b1;                       // ignored outside LOAD_A
    issue(8'h10, 8'h10, 1'b0, lat);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
`ifdef MULT_ACCUM_EN
    model_acc = 16'd0;
    exp_count++;
    exp_count--;
`endif
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p) $display("FAIL accum_second: got %h%h want %h", hi, lo, p);
    else n_pass++;
    // acc_clr together with the A transfer: clear wins, A still taken.
    model_op(8'h01, 8'h01, 1'b1, p);
    issue(8'h01, 8'h01, 1'b1, lat);
    take(lo, hi);
    n_chk++;
    if ({hi, lo} !== p || p !== 16'h0001) $display("FAIL accum_clr_a: got %h%h want %h (0001)", hi, lo, p);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] p;
    logic [7:0] a, b, lo, hi;
    logic clr;
    int lat, stall, errs;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      clr = ($urandom_range(0, 3) == 0);
      stall = $urandom_range(0, 3);
      model_op(a, b, clr, p);
      issue(a, b, clr, lat);
      repeat (stall) @(negedge clk);
      take(lo, hi);
      n_chk++;
      if ({hi, lo} !== p) $display("FAIL random_op%0d: %h*%h got %h%h want %h", i, a, b, hi, lo, p);
      else n_pass++;
    end
    n_chk++;
    if (op_count !== CNT_W'(exp_count))
      $display("FAIL random_count_wrap: got %0d want %0d", op_count, exp_count % (1 << CNT_W));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_accum();
    test_random();
    n_chk++;
    if (both_cnt !== 0) $display("FAIL ready_valid_overlap: got %0d cycles want 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
